// File: rtl/imem_loadable.sv
// -----------------------------------------------------------------------------
// imem_loadable
// Instruction memory that a host loads as a stream of words. The CPU fetch
// stage then reads it through a request/valid handshake with one cycle of
// latency.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   load_start           pulse: restart a program load at word 0
//   load_valid/data/last load beat stream (last sampled with valid)
//   load_ready           beat accepted this cycle (state LOAD)
//   load_done            one-cycle pulse after the terminating beat
//   load_ovf             sticky: array filled before load_last was seen
//   load_count           words written by the most recent load
//   fetch_req, pc        fetch request and byte address
//   fetch_ready          fetch accepted this cycle (state RUN)
//   instr_valid          instr/instr_fault hold the previous cycle's fetch
//   instr, instr_fault   fetched word, or NOP_WORD with fault set
// -----------------------------------------------------------------------------
module imem_loadable #(
  parameter int              ADDR_W   = 11,
  parameter int              DATA_W   = 32,
  parameter int              PC_W     = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              load_ovf,
  output logic [ADDR_W:0]   load_count,
  input  logic              fetch_req,
  input  logic [PC_W-1:0]   pc,
  output logic              fetch_ready,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic              instr_fault
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W:0]     r_wptr;
  logic                r_ovf;
  logic                r_done;
  logic                r_ivalid;
  logic [DATA_W-1:0]   r_instr;
  logic                r_fault;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_beat;
  logic                w_term;
  logic                w_ovf_hit;
  logic                w_fetch_acc;
  logic                w_at_end;
  logic [ADDR_W-1:0]   w_rd_idx;
  logic                w_pc_bad;

  assign w_at_end = (r_wptr == LAST_IDX);
  assign w_rd_idx = pc[ADDR_W+1:2];
  // Misaligned, or any address bit above the array's byte range set.
  assign w_pc_bad = (pc[1:0] != 2'b00) || ((pc >> (ADDR_W + 2)) != '0);

  // Handshake readies depend on state only, never on inputs.
  assign load_ready  = (r_state == S_LOAD);
  assign fetch_ready = (r_state == S_RUN);

  always_comb begin
    w_state_next = r_state;
    w_beat       = 1'b0;
    w_term       = 1'b0;
    w_ovf_hit    = 1'b0;
    w_fetch_acc  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load_start) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        // A beat coinciding with load_start is dropped; the load restarts.
        if (load_start) begin
          w_state_next = S_LOAD;
        end else if (load_valid) begin
          w_beat = 1'b1;
          if (load_last || w_at_end) begin
            w_term       = 1'b1;
            w_ovf_hit    = !load_last;
            w_state_next = S_RUN;
          end
        end
      end
      S_RUN: begin
        // A fetch in the load_start cycle is not accepted.
        if (load_start) w_state_next = S_LOAD;
        else            w_fetch_acc  = fetch_req;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_wptr   <= '0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
      r_ivalid <= 1'b0;
      r_instr  <= NOP_WORD;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_done   <= w_term;
      r_ivalid <= w_fetch_acc;
      if (load_start) begin
        r_wptr <= '0;
        r_ovf  <= 1'b0;
      end else if (w_beat) begin
        r_wptr <= r_wptr + 1'b1;
        if (w_ovf_hit) r_ovf <= 1'b1;
      end
      // instr/instr_fault only change on an accepted fetch, so they hold
      // their last value while instr_valid is low.
      if (w_fetch_acc) begin
        r_fault <= w_pc_bad;
        r_instr <= w_pc_bad ? NOP_WORD : r_mem[w_rd_idx];
      end
    end
  end

  // Storage is deliberately outside the reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_beat) r_mem[r_wptr[ADDR_W-1:0]] <= load_data;
  end

  assign load_done   = r_done;
  assign load_ovf    = r_ovf;
  assign load_count  = r_wptr;
  assign instr_valid = r_ivalid;
  assign instr       = r_instr;
  assign instr_fault = r_fault;

endmodule
